bid_collector10: RTL
====================

// Module: bid_collector10
// PURPOSE
//  Upstream stage of the 10-way argmax auction. Accepts bids serially over a valid/ready port,
//  assembles one round (10 bidder slots), and presents a stable bid vector plus a one-cycle
//  round_valid to the argmax stage. Also emits win_valid, aligned with that stage's registered winner.
// PARAMETERS
//  bW           16   bid value width (must match argmax stage)
//  TIMEOUT_CYC  64   cycles after first accepted bid before round closes with missing bidders; >=2
//  RID_W        8    round_id counter width
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            synchronous, active-high reset
//  bid_valid    in   1            bid offered
//  bid_ready    out  1            collector accepts; transfer = bid_valid & bid_ready
//  bid_id       in   4            bidder index 0..9; 10..15 illegal
//  bid_value    in   bW           bid amount, unsigned
//  bids_out     out  bW x [0:9]   assembled bids; drives argmax bids[]
//  round_valid  out  1            1-cycle pulse: bids_out is a closed round
//  round_mask   out  10           bit i = bidder i bid this round (valid with round_valid)
//  round_id     out  RID_W        id of the round presented; increments after each issue
//  win_valid    out  1            round_valid delayed 1 cycle = argmax win_out valid
//  err_dup      out  1            1-cycle pulse, cycle after a duplicate bid was dropped
//  err_bad_id   out  1            1-cycle pulse, cycle after an illegal-id bid was dropped
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE; bids_out all 0, round_mask 0, round_id 0, round_valid 0,
//   win_valid 0, err_* 0, timer 0. bid_ready=0 while rst=1. Mid-round reset aborts the round:
//   no round_valid, collected bids discarded.
//  FSM: IDLE -> COLLECT on first legal accepted bid (timer cleared to 0 on that edge).
//   COLLECT: timer +1 per cycle. -> ISSUE when (mask incl. this cycle's accept == 10'h3FF)
//   or (timer == TIMEOUT_CYC-1). ISSUE -> IDLE unconditionally after 1 cycle.
//  bid_ready = 1 in IDLE and COLLECT, 0 in ISSUE.
//  Accept rules: legal id with mask[id]=0 -> slot[id]<=bid_value, mask[id]<=1.
//   mask[id]=1 -> value dropped (first bid wins), err_dup pulse. id>=10 -> dropped, err_bad_id
//   pulse, no FSM transition (illegal bid in IDLE does not open a round).
//  Bid accepted in the timeout cycle is included in that round.
//  ISSUE cycle: round_valid=1, bids_out stable; unbid slots read 0. round_mask valid.
//  ISSUE -> IDLE edge: slots/mask cleared to 0, round_id += 1 (wraps at 2^RID_W), win_valid=1 next cycle.
//  Latency: 10th bid accepted at edge N -> round_valid high in cycle N+1 -> win_valid in N+2.
//  Timeout: first bid at edge N -> round_valid in cycle N+TIMEOUT_CYC (if not completed earlier).
//  All outputs registered except bid_ready (decoded from state & rst).
// STRUCTURE
//  auction_pkg: localparam N_BIDDERS=10, IDX_W=4; typedef enum {IDLE,COLLECT,ISSUE} coll_state_t.
//  Sub-module bid_round_timer (clear, enable, TIMEOUT_CYC -> expire) instantiated once.
//  Slot storage: 10 x bW regs + 10-bit mask, write-enabled by decoded bid_id.
// TESTING
//  1. Bids id0..9 values 10..19 on consecutive cycles -> round_valid 1 cycle after id9, mask 3FF,
//     bids_out[9]=19; win_valid next cycle; with argmax attached win_out=9.
//  2. Only ids 3 (val 500) and 7 (val 20), TIMEOUT_CYC=64 -> round_valid exactly 64 cycles after
//     id3 accept, mask 0x088, other slots 0, argmax winner 3.
//  3. id4 val 100 then id4 val 900 -> err_dup pulse, slot4 stays 100 at issue.
//  4. id12 in IDLE -> err_bad_id pulse, state stays IDLE, no timer start, no round_valid.
//  5. bid_valid held high during ISSUE -> bid_ready=0 that cycle, bid taken next cycle into new round
//     (mask has only that bit); round_id increments 0->1; force RID wrap 255->0.
//  6. rst=1 mid-COLLECT with 5 bids -> no round_valid, bids_out/mask 0, round_id unchanged at 0,
//     next bid after rst opens a fresh round.

Source files
------------

// File: rtl/auction_pkg.sv
`default_nettype none
// ============================================================================
// Module      : auction_pkg
// Description : Shared constants and types for the 10-way argmax auction.
// Revision    : 1.0 - initial release
// ============================================================================
package auction_pkg;

    localparam int N_BIDDERS = 10;
    localparam int IDX_W     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2
    } coll_state_t;

endpackage : auction_pkg
`default_nettype wire

// File: rtl/bid_round_timer.sv
`default_nettype none
// ============================================================================
// Module      : bid_round_timer
// Description : Round age counter; flags the edge on which a round must close.
// Revision    : 1.0 - initial release
// ============================================================================
module bid_round_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int                 c_cnt_w = $clog2(TIMEOUT_CYC);
    // Expire while the count is one short, so the close edge is the one
    // that would carry the timer to TIMEOUT_CYC-1.
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT_CYC - 2);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_enable && (r_count == c_last);

endmodule : bid_round_timer
`default_nettype wire

// File: rtl/bid_collector10.sv
`default_nettype none
// ============================================================================
// Module      : bid_collector10
// Description : Serial bid collector; assembles 10-slot rounds for the argmax.
// Revision    : 1.0 - initial release
// ============================================================================
module bid_collector10
    import auction_pkg::*;
#(
    parameter int bW          = 16,
    parameter int TIMEOUT_CYC = 64,
    parameter int RID_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bid_valid,
    output logic                 bid_ready,
    input  logic [IDX_W-1:0]     bid_id,
    input  logic [bW-1:0]        bid_value,
    output logic [bW-1:0]        bids_out [0:N_BIDDERS-1],
    output logic                 round_valid,
    output logic [N_BIDDERS-1:0] round_mask,
    output logic [RID_W-1:0]     round_id,
    output logic                 win_valid,
    output logic                 err_dup,
    output logic                 err_bad_id
);

    localparam logic [IDX_W-1:0]     c_n_ids     = IDX_W'(N_BIDDERS);
    localparam logic [N_BIDDERS-1:0] c_full_mask = '1;
    localparam logic [N_BIDDERS-1:0] c_bit0      = N_BIDDERS'(1);

    coll_state_t            r_state;
    logic [bW-1:0]          r_slot [0:N_BIDDERS-1];
    logic [N_BIDDERS-1:0]   r_mask;
    logic [RID_W-1:0]       r_round_id;
    logic                   r_round_valid;
    logic                   r_win_valid;
    logic                   r_err_dup;
    logic                   r_err_bad_id;

    logic                   w_xfer;
    logic                   w_legal;
    logic                   w_seen;
    logic                   w_accept;
    logic [N_BIDDERS-1:0]   w_mask_next;
    logic                   w_expire;

    assign bid_ready   = !rst && (r_state != ISSUE);
    assign w_xfer      = bid_valid && bid_ready;
    assign w_legal     = (bid_id < c_n_ids);
    assign w_seen      = w_legal && r_mask[bid_id];
    assign w_accept    = w_xfer && w_legal && !w_seen;
    assign w_mask_next = w_accept ? (r_mask | (c_bit0 << bid_id)) : r_mask;

    bid_round_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  ((r_state == IDLE) && w_accept),
        .i_enable (r_state == COLLECT),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_mask        <= '0;
            r_round_id    <= '0;
            r_round_valid <= 1'b0;
            r_win_valid   <= 1'b0;
            r_err_dup     <= 1'b0;
            r_err_bad_id  <= 1'b0;
            for (int i = 0; i < N_BIDDERS; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_err_dup     <= w_xfer && w_legal && w_seen;
            r_err_bad_id  <= w_xfer && !w_legal;
            r_win_valid   <= r_round_valid;
            r_round_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if ((w_mask_next == c_full_mask) || w_expire) begin
                        r_state       <= ISSUE;
                        r_round_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_state    <= IDLE;
                    r_round_id <= r_round_id + 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Slots stay frozen through ISSUE and are wiped as it ends.
            if (r_state == ISSUE) begin
                r_mask <= '0;
                for (int i = 0; i < N_BIDDERS; i++) begin
                    r_slot[i] <= '0;
                end
            end else if (w_accept) begin
                r_mask         <= w_mask_next;
                r_slot[bid_id] <= bid_value;
            end
        end
    end

    assign bids_out    = r_slot;
    assign round_valid = r_round_valid;
    assign round_mask  = r_mask;
    assign round_id    = r_round_id;
    assign win_valid   = r_win_valid;
    assign err_dup     = r_err_dup;
    assign err_bad_id  = r_err_bad_id;

endmodule : bid_collector10
`default_nettype wire
